regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: A (single-cycle ALU pipe) and B (multi-cycle mul/div/load unit).
- Arbitrates A and B round-robin and registers the winning beat onto the write port.
- Keeps a per-register pending-write scoreboard so decode can detect RAW hazards and stall issue.
- Sits between the execute/memory stages and the register file write inputs.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 5, register address width; the number of registers is 2**ADDR_WIDTH.
- CNT_WIDTH, 2, width of the per-register pending-write counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode issues an instruction that will later write issue_rd.
- issue_rd  in  ADDR_WIDTH  destination register being reserved.
- issue_stall  out  1  issue refused this cycle (counter saturated).
- a_valid  in  1  requester A has a writeback beat.
- a_ready  out  1  A beat accepted this cycle.
- a_rd  in  ADDR_WIDTH  A destination.
- a_data  in  DATA_WIDTH  A write value.
- b_valid  in  1  requester B has a writeback beat.
- b_ready  out  1  B beat accepted this cycle.
- b_rd  in  ADDR_WIDTH  B destination.
- b_data  in  DATA_WIDTH  B write value.
- reg_write  out  1  register file write enable.
- rd_address  out  ADDR_WIDTH  register file write address.
- rd_value  out  DATA_WIDTH  register file write data.
- busy  out  2**ADDR_WIDTH  bit r = 1 when register r has at least one pending write.
- protocol_err  out  1  sticky: a commit arrived for a register with zero pending writes.

Behaviour:
- Reset (async, rst_n=0):
  - All pending counters clear to 0.
  - reg_write=0, rd_address=0, rd_value=0, protocol_err=0.
  - last_grant=B, so A wins the first tie.
  - In-flight registered beats are discarded; a_ready/b_ready stay 0 while in reset.
- Arbitration (combinational from current inputs and last_grant):
  - Only A valid: a_ready=1. Only B valid: b_ready=1.
  - Both valid: grant the requester not equal to last_grant; the other sees ready=0 and must hold valid, rd and data stable.
  - At most one ready is high per cycle.
  - last_grant updates to the winner on any accepted beat; it is unchanged on idle cycles.
- Transfer: a beat transfers when valid && ready.
- Write port stage (1-cycle latency):
  - Accepted beat appears on rd_address/rd_value on the next cycle.
  - reg_write=1 for exactly that cycle when its rd != 0.
  - An accepted beat with rd=0 still consumes its slot and handshakes, but reg_write stays 0.
  - With no accepted beat, reg_write=0 and rd_address/rd_value hold their previous values.
- Throughput: one writeback per cycle sustained; no bubbles when requesters are back-to-back.
- Scoreboard, per-register counter cnt[r] (CNT_WIDTH bits):
  - inc: issue_valid && !issue_stall && issue_rd != 0, on cnt[issue_rd].
  - dec: reg_write && cnt[rd_address] != 0, on the cycle reg_write is high (commit).
  - inc and dec on the same register in the same cycle: cnt unchanged.
  - issue_stall = issue_valid && issue_rd != 0 && cnt[issue_rd] == max && no dec of issue_rd this cycle. A stalled issue has no effect.
  - Commit with cnt[rd_address]==0: cnt stays 0 and protocol_err sets and stays 1 until reset.
  - busy[r] = (cnt[r] != 0); busy[0] is always 0. busy reflects registered counter state only, with no same-cycle bypass.

Test Plan:
- Reset, then a_valid=1, a_rd=5, a_data=0xDEADBEEF for one cycle → a_ready=1 same cycle; next cycle reg_write=1, rd_address=5, rd_value=0xDEADBEEF; following cycle reg_write=0.
- A and B both valid for 4 cycles (A rd=1..4, B rd=9..12, each holding until accepted) → grants alternate A,B,A,B; write port shows 1,9,2,10 on consecutive cycles with no bubbles.
- issue_valid with issue_rd=7 → busy[7]=1 next cycle; later B writes rd=7 → busy[7]=0 the cycle after reg_write.
- Issue rd=3 three times, then a fourth issue → issue_stall=1, cnt[3] stays 3; the same fourth issue in a cycle where a commit to 3 occurs → no stall, cnt stays 3.
- A beat with a_rd=0 → a_ready=1, reg_write stays 0, busy unchanged; issue_rd=0 → no busy change, no stall.
- Commit to rd=20 with no prior issue → protocol_err=1 and stays set; assert rst_n=0 mid-stream with both valid → all outputs zero immediately and busy all zero.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the single register file write port.
// Also keeps a per-register pending-write scoreboard for RAW hazard stalls.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   issue_valid/issue_rd            reserve a pending write on issue_rd
//   issue_stall                     issue refused (counter saturated)
//   a_valid/a_ready/a_rd/a_data     requester A writeback beat
//   b_valid/b_ready/b_rd/b_data     requester B writeback beat
//   reg_write/rd_address/rd_value   registered register file write port
//   busy                            bit r set while register r has pending writes
//   protocol_err                    sticky: commit to a register with no pending write
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid,
    input  logic [ADDR_WIDTH-1:0]    issue_rd,
    output logic                     issue_stall,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [ADDR_WIDTH-1:0]    a_rd,
    input  logic [DATA_WIDTH-1:0]    a_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [ADDR_WIDTH-1:0]    b_rd,
    input  logic [DATA_WIDTH-1:0]    b_data,
    output logic                     reg_write,
    output logic [ADDR_WIDTH-1:0]    rd_address,
    output logic [DATA_WIDTH-1:0]    rd_value,
    output logic [2**ADDR_WIDTH-1:0] busy,
    output logic                     protocol_err
);

    localparam int NREG = 2**ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    grant_e                  last_grant_q, last_grant_d;
    logic                    reg_write_q, reg_write_d;
    logic [ADDR_WIDTH-1:0]   rd_address_q, rd_address_d;
    logic [DATA_WIDTH-1:0]   rd_value_q, rd_value_d;
    logic                    err_q, err_d;
    logic [CNT_WIDTH-1:0]    cnt_q [NREG];
    logic [CNT_WIDTH-1:0]    cnt_d [NREG];

    logic a_fire, b_fire;
    logic dec_en, inc_en, commit_zero;

    // Ready is forced low while reset is asserted.
    assign a_ready = rst_n && a_valid &&
                     (!b_valid || last_grant_q == GRANT_B);
    assign b_ready = rst_n && b_valid &&
                     (!a_valid || last_grant_q == GRANT_A);

    assign a_fire = a_valid && a_ready;
    assign b_fire = b_valid && b_ready;

    always_comb begin
        last_grant_d = last_grant_q;
        reg_write_d  = 1'b0;
        rd_address_d = rd_address_q;
        rd_value_d   = rd_value_q;
        if (a_fire) begin
            last_grant_d = GRANT_A;
            reg_write_d  = (a_rd != '0);
            rd_address_d = a_rd;
            rd_value_d   = a_data;
        end else if (b_fire) begin
            last_grant_d = GRANT_B;
            reg_write_d  = (b_rd != '0);
            rd_address_d = b_rd;
            rd_value_d   = b_data;
        end
    end

    // The commit being presented this cycle retires one pending write.
    assign commit_zero = reg_write_q && (cnt_q[rd_address_q] == '0);
    assign dec_en      = reg_write_q && (cnt_q[rd_address_q] != '0);

    // A saturated counter can still accept an issue if it is
    // retiring a write in the same cycle.
    assign issue_stall = rst_n && issue_valid && (issue_rd != '0) &&
                         (cnt_q[issue_rd] == CNT_MAX) &&
                         !(reg_write_q && rd_address_q == issue_rd);

    assign inc_en = issue_valid && !issue_stall && (issue_rd != '0);

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc_en && issue_rd == ADDR_WIDTH'(r) &&
                !(dec_en && rd_address_q == ADDR_WIDTH'(r))) begin
                cnt_d[r] = cnt_q[r] + CNT_WIDTH'(1);
            end else if (dec_en && rd_address_q == ADDR_WIDTH'(r) &&
                         !(inc_en && issue_rd == ADDR_WIDTH'(r))) begin
                cnt_d[r] = cnt_q[r] - CNT_WIDTH'(1);
            end
        end
    end

    assign err_d = err_q | commit_zero;

    always_comb begin
        busy = '0;
        for (int r = 1; r < NREG; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_B;
            reg_write_q  <= 1'b0;
            rd_address_q <= '0;
            rd_value_q   <= '0;
            err_q        <= 1'b0;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            reg_write_q  <= reg_write_d;
            rd_address_q <= rd_address_d;
            rd_value_q   <= rd_value_d;
            err_q        <= err_d;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign reg_write    = reg_write_q;
    assign rd_address   = rd_address_q;
    assign rd_value     = rd_value_q;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a
// behavioural model of arbitration, write port and scoreboard.
module tb_regfile_wb_arbiter;

    localparam int CMAX = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_stall;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [4:0]  a_rd = '0;
    logic [31:0] a_data = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_rd = '0;
    logic [31:0] b_data = '0;
    logic        reg_write;
    logic [4:0]  rd_address;
    logic [31:0] rd_value;
    logic [31:0] busy;
    logic        protocol_err;

    regfile_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_stall(issue_stall),
        .a_valid(a_valid), .a_ready(a_ready),
        .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready),
        .b_rd(b_rd), .b_data(b_data),
        .reg_write(reg_write), .rd_address(rd_address),
        .rd_value(rd_value), .busy(busy),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          cnt [32];
    bit          lg_b;
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_val;
    bit          m_err;
    bit          a_acc, b_acc;
    bit          obs_a, obs_b, obs_stall;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) cnt[i] = 0;
        lg_b   = 1'b1;
        m_we   = 1'b0;
        m_addr = '0;
        m_val  = '0;
        m_err  = 1'b0;
        a_acc  = 1'b0;
        b_acc  = 1'b0;
    endtask

    function automatic logic [31:0] exp_busy();
        logic [31:0] v;
        v = '0;
        for (int i = 1; i < 32; i++) v[i] = (cnt[i] > 0);
        return v;
    endfunction

    task automatic check_regs();
        check("reg_write", 64'(reg_write), 64'(m_we));
        check("rd_address", 64'(rd_address), 64'(m_addr));
        check("rd_value", 64'(rd_value), 64'(m_val));
        check("busy", 64'(busy), 64'(exp_busy()));
        check("protocol_err", 64'(protocol_err), 64'(m_err));
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        bit ea, eb, es;
        int nc [32];
        #1;
        ea = a_valid && (!b_valid || lg_b);
        eb = b_valid && (!a_valid || !lg_b);
        es = issue_valid && issue_rd != 0 && cnt[issue_rd] == CMAX &&
             !(m_we && m_addr == issue_rd);
        check("a_ready", 64'(a_ready), 64'(ea));
        check("b_ready", 64'(b_ready), 64'(eb));
        check("issue_stall", 64'(issue_stall), 64'(es));
        obs_a = a_ready;
        obs_b = b_ready;
        obs_stall = issue_stall;
        a_acc = ea;
        b_acc = eb;
        @(posedge clk);
        nc = cnt;
        if (m_we) begin
            if (cnt[m_addr] > 0) nc[m_addr] = nc[m_addr] - 1;
            else m_err = 1'b1;
        end
        if (issue_valid && !es && issue_rd != 0)
            nc[issue_rd] = nc[issue_rd] + 1;
        cnt = nc;
        if (ea) begin
            m_we = (a_rd != 0); m_addr = a_rd; m_val = a_data; lg_b = 1'b0;
        end else if (eb) begin
            m_we = (b_rd != 0); m_addr = b_rd; m_val = b_data; lg_b = 1'b1;
        end else begin
            m_we = 1'b0;
        end
        @(negedge clk);
        check_regs();
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_rd = 0;
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [4:0] pick();
        if ($urandom_range(0, 9) < 6) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    int ai, bi, n;
    logic [4:0] seq [16];

    initial begin
        @(negedge clk);
        do_reset();

        // Single A beat
        a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
        cycle();
        check("t1_a_ready", 64'(obs_a), 64'd1);
        check("t1_we", 64'(reg_write), 64'd1);
        check("t1_addr", 64'(rd_address), 64'd5);
        check("t1_val", 64'(rd_value), 64'hDEADBEEF);
        idle_inputs();
        cycle();
        check("t1_we_off", 64'(reg_write), 64'd0);

        // Both requesters contending
        do_reset();
        ai = 0; bi = 0; n = 0;
        for (int k = 0; k < 12 && (ai < 4 || bi < 4 || reg_write); k++) begin
            a_valid = (ai < 4); a_rd = 5'(1 + ai); a_data = 32'(100 + ai);
            b_valid = (bi < 4); b_rd = 5'(9 + bi); b_data = 32'(200 + bi);
            cycle();
            if (a_acc) ai++;
            if (b_acc) bi++;
            if (reg_write && n < 16) begin seq[n] = rd_address; n++; end
        end
        idle_inputs();
        check("t2_count", 64'(n), 64'd8);
        check("t2_seq0", 64'(seq[0]), 64'd1);
        check("t2_seq1", 64'(seq[1]), 64'd9);
        check("t2_seq2", 64'(seq[2]), 64'd2);
        check("t2_seq3", 64'(seq[3]), 64'd10);

        // Busy tracking through a B commit
        do_reset();
        issue_valid = 1; issue_rd = 7;
        cycle();
        check("t3_busy7", 64'(busy[7]), 64'd1);
        idle_inputs();
        b_valid = 1; b_rd = 7; b_data = 32'h77;
        cycle();
        idle_inputs();
        cycle();
        check("t3_busy7_clr", 64'(busy[7]), 64'd0);

        // Saturation and commit bypass
        for (int k = 0; k < 3; k++) begin
            issue_valid = 1; issue_rd = 3;
            cycle();
        end
        cycle();
        check("t4_stall", 64'(obs_stall), 64'd1);
        idle_inputs();
        a_valid = 1; a_rd = 3; a_data = 32'h33;
        cycle();
        idle_inputs();
        issue_valid = 1; issue_rd = 3;
        cycle();
        check("t4_nostall", 64'(obs_stall), 64'd0);
        cycle();
        check("t4_stall_again", 64'(obs_stall), 64'd1);

        // Register zero
        idle_inputs();
        a_valid = 1; a_rd = 0; a_data = 32'h1234;
        issue_valid = 1; issue_rd = 0;
        cycle();
        check("t5_a_ready", 64'(obs_a), 64'd1);
        check("t5_nostall", 64'(obs_stall), 64'd0);
        check("t5_we", 64'(reg_write), 64'd0);
        check("t5_busy0", 64'(busy[0]), 64'd0);

        // Commit with no pending write
        idle_inputs();
        a_valid = 1; a_rd = 20; a_data = 32'h20;
        cycle();
        idle_inputs();
        cycle();
        check("t6_err", 64'(protocol_err), 64'd1);
        cycle();
        cycle();
        check("t6_err_sticky", 64'(protocol_err), 64'd1);

        // Reset asserted mid-stream
        a_valid = 1; a_rd = 2; a_data = 32'hA;
        b_valid = 1; b_rd = 4; b_data = 32'hB;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_a_ready", 64'(a_ready), 64'd0);
        check("rst_b_ready", 64'(b_ready), 64'd0);
        check("rst_we", 64'(reg_write), 64'd0);
        check("rst_addr", 64'(rd_address), 64'd0);
        check("rst_val", 64'(rd_value), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(protocol_err), 64'd0);
        @(negedge clk);
        do_reset();

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            if (k % 150 == 149) do_reset();
            if (!a_valid || a_acc) begin
                a_valid = $urandom_range(0, 1) != 0;
                a_rd = pick(); a_data = $urandom;
            end
            if (!b_valid || b_acc) begin
                b_valid = $urandom_range(0, 1) != 0;
                b_rd = pick(); b_data = $urandom;
            end
            issue_valid = $urandom_range(0, 1) != 0;
            issue_rd = pick();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
